led_breath_sequencer: RTL

//   Sequences the single-LED breathing driver across an 8-LED bar: picks which LED breathes,
//   for how many breath periods, and inserts dark gaps. Sits between mode/key logic and the

---
 rtl/led_breath_sequencer_pkg.sv | 42 ++++
 rtl/led_period_timer.sv | 41 ++++
 rtl/led_breath_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/led_breath_sequencer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : led_breath_sequencer_pkg
// Description : Shared encodings for the LED-bar breathing sequencer:
//               pattern codes, FSM state codes, default bar size and the
//               start-index helper used when a sequence (re)starts.
// Revision    : 1.0 - initial release
// ============================================================================
package led_breath_sequencer_pkg;

  localparam int NUM_LED_DEF = 8;
  // Index arithmetic is done on 3 bits; led_select pads the upper bit with 0.
  localparam int IDX_W       = 3;

  // Pattern encodings (value of the 2-bit pattern input)
  localparam logic [1:0] PAT_FIXED      = 2'd0;
  localparam logic [1:0] PAT_CHASE_UP   = 2'd1;
  localparam logic [1:0] PAT_CHASE_DOWN = 2'd2;
  localparam logic [1:0] PAT_PINGPONG   = 2'd3;

  // Sequencer FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BREATH = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  // LED index a sequence starts on when leaving IDLE.
  function automatic logic [IDX_W-1:0] start_index(
    input logic [1:0]       pat,
    input logic [IDX_W-1:0] fsel,
    input logic [IDX_W-1:0] last
  );
    case (pat)
      PAT_FIXED:      return fsel;
      PAT_CHASE_DOWN: return last;
      default:        return '0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_period_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : led_period_timer
// Description : Free-running modulo-PERIOD counter. period_tick is a
//               combinational decode of the last count (PERIOD-1), so it is
//               high for exactly one cycle per period.
// Ports       : clk          in  system clock
//               rst_n        in  asynchronous active-low reset
//               period_tick  out 1-cycle pulse on the last cycle of a period
// Revision    : 1.0 - initial release
// ============================================================================
module led_period_timer #(
  parameter int PERIOD = 600
) (
  input  logic clk,
  input  logic rst_n,
  output logic period_tick
);

  localparam int              CNT_W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;

  // Never gated: the count must stay phase-aligned with the breath driver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign period_tick = (r_cnt == c_cnt_last);

endmodule

`default_nettype wire

// File: rtl/led_breath_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : led_breath_sequencer
// Description : Chooses which LED of the bar the breathing driver animates,
//               how many breath periods it stays there and when dark gaps are
//               inserted. All sequencing happens on period boundaries; only
//               enable=0 acts immediately (on the next clock edge).
// Ports       : clk          in  system clock
//               rst_n        in  asynchronous active-low reset
//               enable       in  1 = run sequence, 0 = go dark
//               pattern      in  FIXED / CHASE_UP / CHASE_DOWN / PINGPONG
//               fixed_sel    in  LED index for the FIXED pattern
//               led_select   out LED index to the breath driver (MSB = 0)
//               led_gate     out 1 = pass driver output, 0 = force dark
//               period_tick  out pulse on the last cycle of every period
//               step_pulse   out pulse with period_tick when led_select moves
// Revision    : 1.0 - initial release
// ============================================================================
module led_breath_sequencer
  import led_breath_sequencer_pkg::*;
#(
  parameter int PERIOD  = 600,
  parameter int REPEATS = 2,
  parameter int GAP     = 1,
  parameter int NUM_LED = NUM_LED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] pattern,
  input  logic [2:0] fixed_sel,
  output logic [3:0] led_select,
  output logic       led_gate,
  output logic       period_tick,
  output logic       step_pulse
);

  localparam int REP_W    = $clog2(REPEATS + 1);
  localparam int GAP_W    = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [REP_W-1:0] c_rep_last = REP_W'(REPEATS - 1);
  localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(GAP_LAST);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_LED - 1);

  // Registered state
  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_gate;
  logic [REP_W-1:0] r_rep;
  logic [GAP_W-1:0] r_gap;
  logic             r_dir;   // 1 = ascending (PINGPONG only)
  logic [1:0]       r_pat;   // pattern seen at the previous boundary

  // Next-state wires
  logic [1:0]       w_state_nx;
  logic [IDX_W-1:0] w_idx_nx;
  logic             w_gate_nx;
  logic [REP_W-1:0] w_rep_nx;
  logic [GAP_W-1:0] w_gap_nx;
  logic             w_dir_nx;

  logic             w_tick;
  logic             w_enter_pp;
  logic             w_dir_eff;
  logic [IDX_W-1:0] w_adv_idx;
  logic             w_adv_dir;

  led_period_timer #(
    .PERIOD (PERIOD)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .period_tick (w_tick)
  );

  // Switching into PINGPONG starts upward unless already parked on the top
  // LED; the decision is made from the index held at this boundary.
  assign w_enter_pp = (pattern == PAT_PINGPONG) && (r_pat != PAT_PINGPONG);
  assign w_dir_eff  = w_enter_pp ? (r_idx != c_idx_last) : r_dir;

  // Next LED index when a visit ends, computed with the current pattern.
  always_comb begin
    w_adv_idx = r_idx;
    w_adv_dir = w_dir_eff;
    case (pattern)
      PAT_FIXED: begin
        w_adv_idx = fixed_sel;
      end
      PAT_CHASE_UP: begin
        w_adv_idx = (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
      end
      PAT_CHASE_DOWN: begin
        w_adv_idx = (r_idx == '0) ? c_idx_last : r_idx - IDX_W'(1);
      end
      default: begin
        // Reverse at the ends without repeating the end index.
        if (w_dir_eff) begin
          if (r_idx == c_idx_last) begin
            w_adv_idx = r_idx - IDX_W'(1);
            w_adv_dir = 1'b0;
          end else begin
            w_adv_idx = r_idx + IDX_W'(1);
          end
        end else begin
          if (r_idx == '0) begin
            w_adv_idx = IDX_W'(1);
            w_adv_dir = 1'b1;
          end else begin
            w_adv_idx = r_idx - IDX_W'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_gate_nx  = r_gate;
    w_rep_nx   = r_rep;
    w_gap_nx   = r_gap;
    w_dir_nx   = r_dir;
    if (!enable) begin
      // Going dark is immediate; led_select is left where it was.
      w_state_nx = ST_IDLE;
      w_gate_nx  = 1'b0;
      w_rep_nx   = '0;
      w_gap_nx   = '0;
    end else if (w_tick) begin
      w_dir_nx = w_dir_eff;
      case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_BREATH;
          w_idx_nx   = start_index(pattern, fixed_sel, c_idx_last);
          w_dir_nx   = 1'b1;
          w_gate_nx  = 1'b1;
          w_rep_nx   = '0;
        end
        ST_BREATH: begin
          if (r_rep != c_rep_last) begin
            w_rep_nx = r_rep + REP_W'(1);
          end else begin
            w_rep_nx = '0;
            if (GAP > 0) begin
              w_state_nx = ST_GAP;
              w_gate_nx  = 1'b0;
              w_gap_nx   = '0;
            end else begin
              w_idx_nx = w_adv_idx;
              w_dir_nx = w_adv_dir;
            end
          end
        end
        ST_GAP: begin
          if (r_gap == c_gap_last) begin
            w_state_nx = ST_BREATH;
            w_gate_nx  = 1'b1;
            w_gap_nx   = '0;
            w_idx_nx   = w_adv_idx;
            w_dir_nx   = w_adv_dir;
          end else begin
            w_gap_nx = r_gap + GAP_W'(1);
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_gate_nx  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_gate  <= 1'b0;
      r_rep   <= '0;
      r_gap   <= '0;
      r_dir   <= 1'b1;
      r_pat   <= PAT_FIXED;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_gate  <= w_gate_nx;
      r_rep   <= w_rep_nx;
      r_gap   <= w_gap_nx;
      r_dir   <= w_dir_nx;
      if (w_tick) begin
        r_pat <= pattern;
      end
    end
  end

  assign led_select  = {{(4 - IDX_W){1'b0}}, r_idx};
  assign led_gate    = r_gate;
  assign period_tick = w_tick;
  // Announces, during the boundary cycle, that the index moves on this edge.
  assign step_pulse  = w_tick && (w_idx_nx != r_idx);

endmodule

`default_nettype wire
